// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ARMv8-subset datapath
// Define MULTICYCLE_MUL_EN to sequence MUL through the MULW state; otherwise MUL decodes as illegal.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] instr_op,
   input  logic        zero,
   input  logic        lt,
   input  logic        dmem_ack,
   input  logic        mul_done,
   output logic        pc_write,
   output logic        pc_sel,
   output logic        ir_write,
   output logic        reg2loc,
   output logic        alu_src,
   output logic        mem_to_reg,
   output logic        shift_dir,
   output logic [2:0]  alu_op,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic        reg_write,
   output logic        mul_start,
   output logic        fault
);

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
`ifdef MULTICYCLE_MUL_EN
      ST_MULW,
`endif
      ST_WB,
      ST_FAULT
   } state_t;

   typedef enum logic [3:0] {
      IC_ILL, IC_ADDI, IC_ADDS, IC_SUBS, IC_B, IC_BLT, IC_CBZ,
      IC_LDUR, IC_STUR, IC_LSL, IC_LSR, IC_MUL
   } iclass_t;

   localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [10:0] op_q, op_d;
   logic [3:0]  to_cnt_q, to_cnt_d;
   logic        active_q;
   iclass_t     cls;

`ifndef MULTICYCLE_MUL_EN
   logic unused_mul_done;
   assign unused_mul_done = mul_done;
`endif

   always_comb begin
      cls = IC_ILL;
      casez (op_q)
         11'b10010001000: cls = IC_ADDI;
         11'b10101011000: cls = IC_ADDS;
         11'b11101011000: cls = IC_SUBS;
         11'b000101?????: cls = IC_B;
         11'b01010100???: cls = IC_BLT;
         11'b10110100???: cls = IC_CBZ;
         11'b11111000010: cls = IC_LDUR;
         11'b11111000000: cls = IC_STUR;
         11'b11010011011: cls = IC_LSL;
         11'b11010011010: cls = IC_LSR;
`ifdef MULTICYCLE_MUL_EN
         11'b10011011000: cls = IC_MUL;
`endif
         default:         cls = IC_ILL;
      endcase
   end

   // active_q holds the sequencer idle for the first cycle after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_FETCH;
         op_q     <= '0;
         to_cnt_q <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         to_cnt_q <= to_cnt_d;
         active_q <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      to_cnt_d   = to_cnt_q;
      pc_write   = 1'b0;
      pc_sel     = 1'b0;
      ir_write   = 1'b0;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      shift_dir  = 1'b0;
      alu_op     = 3'b000;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      reg_write  = 1'b0;
      mul_start  = 1'b0;
      fault      = 1'b0;
      if (active_q) begin
         case (state_q)
            ST_FETCH: begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               op_d     = instr_op;
               state_d  = ST_DECODE;
            end
            ST_DECODE: begin
               reg2loc = (cls == IC_CBZ) || (cls == IC_STUR);
               if (cls == IC_ILL) begin
                  state_d = ST_FAULT;
`ifdef MULTICYCLE_MUL_EN
               end else if (cls == IC_MUL) begin
                  mul_start = 1'b1;
                  state_d   = ST_MULW;
`endif
               end else begin
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (cls)
                  IC_ADDI, IC_LDUR, IC_STUR: begin
                     alu_src = 1'b1;
                     alu_op  = 3'b010;
                  end
                  IC_ADDS: alu_op = 3'b010;
                  IC_SUBS: alu_op = 3'b011;
                  IC_LSL:  alu_op = 3'b001;
                  IC_LSR: begin
                     alu_op    = 3'b001;
                     shift_dir = 1'b1;
                  end
                  default: alu_op = 3'b000;
               endcase
               if ((cls == IC_B) || ((cls == IC_BLT) && lt) || ((cls == IC_CBZ) && zero)) begin
                  pc_write = 1'b1;
                  pc_sel   = 1'b1;
               end
               if ((cls == IC_B) || (cls == IC_BLT) || (cls == IC_CBZ)) begin
                  state_d = ST_FETCH;
               end else if ((cls == IC_LDUR) || (cls == IC_STUR)) begin
                  to_cnt_d = '0;
                  state_d  = ST_MEM;
               end else begin
                  state_d = ST_WB;
               end
            end
            ST_MEM: begin
               alu_src    = 1'b1;
               alu_op     = 3'b010;
               dmem_read  = (cls == IC_LDUR);
               dmem_write = (cls == IC_STUR);
               // An ack on the final allowed cycle still completes the access.
               if (dmem_ack) begin
                  state_d = (cls == IC_STUR) ? ST_FETCH : ST_WB;
               end else if (to_cnt_q == TO_LAST) begin
                  state_d = ST_FAULT;
               end else begin
                  to_cnt_d = to_cnt_q + 4'd1;
               end
            end
`ifdef MULTICYCLE_MUL_EN
            ST_MULW: begin
               if (mul_done) state_d = ST_WB;
            end
`endif
            ST_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (cls == IC_LDUR);
               state_d    = ST_FETCH;
            end
            ST_FAULT: fault = 1'b1;
            default:  state_d = ST_FAULT;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
   localparam int TO = 15;

   localparam logic [10:0] OP_ADDI = 11'b10010001000;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_LSL  = 11'b11010011011;
   localparam logic [10:0] OP_LSR  = 11'b11010011010;
   localparam logic [10:0] OP_B    = 11'b00010110101;
   localparam logic [10:0] OP_BLT  = 11'b01010100011;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_MUL  = 11'b10011011000;
   localparam logic [10:0] OP_XX   = 11'h7FF;

   localparam logic [14:0] B_PCW  = 15'(1) << 14;
   localparam logic [14:0] B_PCS  = 15'(1) << 13;
   localparam logic [14:0] B_IRW  = 15'(1) << 12;
   localparam logic [14:0] B_R2L  = 15'(1) << 11;
   localparam logic [14:0] B_ASRC = 15'(1) << 10;
   localparam logic [14:0] B_M2R  = 15'(1) << 9;
   localparam logic [14:0] B_SD   = 15'(1) << 8;
   localparam logic [14:0] A_ADD  = 15'(2) << 5;
   localparam logic [14:0] A_SUB  = 15'(3) << 5;
   localparam logic [14:0] A_SHF  = 15'(1) << 5;
   localparam logic [14:0] B_DR   = 15'(1) << 4;
   localparam logic [14:0] B_DW   = 15'(1) << 3;
   localparam logic [14:0] B_RW   = 15'(1) << 2;
   localparam logic [14:0] B_MS   = 15'(1) << 1;
   localparam logic [14:0] B_FLT  = 15'(1);
   localparam logic [14:0] V_F    = B_PCW | B_IRW;
   localparam logic [14:0] V_0    = 15'd0;
   localparam logic [14:0] V_EMEM = B_ASRC | A_ADD;

   logic        clk;
   logic        reset_n;
   logic [10:0] instr_op;
   logic        zero, lt, dmem_ack, mul_done;
   logic        pc_write, pc_sel, ir_write, reg2loc, alu_src, mem_to_reg, shift_dir;
   logic [2:0]  alu_op;
   logic        dmem_read, dmem_write, reg_write, mul_start, fault;
   logic [14:0] outs;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [10:0] op;
      logic [3:0]  ctl;
   } stim_t;

   stim_t       stim_q[$];
   logic [14:0] exp_q[$];

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .instr_op(instr_op), .zero(zero), .lt(lt),
      .dmem_ack(dmem_ack), .mul_done(mul_done), .pc_write(pc_write), .pc_sel(pc_sel),
      .ir_write(ir_write), .reg2loc(reg2loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .shift_dir(shift_dir), .alu_op(alu_op), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .reg_write(reg_write), .mul_start(mul_start), .fault(fault)
   );

   assign outs = {pc_write, pc_sel, ir_write, reg2loc, alu_src, mem_to_reg, shift_dir,
                  alu_op, dmem_read, dmem_write, reg_write, mul_start, fault};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // ctl = {zero, lt, dmem_ack, mul_done} for the cycle; e = expected outputs in that cycle
   task automatic push(input logic [10:0] op, input logic [3:0] ctl, input logic [14:0] e);
      stim_t s;
      s.op  = op;
      s.ctl = ctl;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic apply(input stim_t s);
      instr_op = s.op;
      {zero, lt, dmem_ack, mul_done} = s.ctl;
   endtask

   task automatic test_reset(input string tag);
      reset_n = 1'b0;
      #1;
      total++;
      if (outs !== V_0) begin
         bad++;
         $display("FAIL %s_in_reset got=%b exp=%b", tag, outs, V_0);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (outs !== V_0) begin
         bad++;
         $display("FAIL %s_release_idle got=%b exp=%b", tag, outs, V_0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_alu();
      logic [10:0] ops [5] = '{OP_ADDI, OP_ADDS, OP_SUBS, OP_LSL, OP_LSR};
      logic [14:0] exs [5] = '{B_ASRC | A_ADD, A_ADD, A_SUB, A_SHF, A_SHF | B_SD};
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      for (int i = 0; i < 5; i++) begin
         push(ops[i], 4'b0000, V_F);
         push(OP_XX, 4'b0000, V_0);
         push(OP_XX, 4'b0011, exs[i]);
         push(OP_XX, 4'b0000, B_RW);
      end
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL alu cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_branch();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(OP_CBZ, 4'b0000, V_F); push(OP_XX, 4'b0000, B_R2L); push(OP_XX, 4'b1000, B_PCW | B_PCS);
      push(OP_CBZ, 4'b0000, V_F); push(OP_XX, 4'b0000, B_R2L); push(OP_XX, 4'b0100, V_0);
      push(OP_B,   4'b0000, V_F); push(OP_XX, 4'b0000, V_0);   push(OP_XX, 4'b0010, B_PCW | B_PCS);
      push(OP_BLT, 4'b0000, V_F); push(OP_XX, 4'b0000, V_0);   push(OP_XX, 4'b0100, B_PCW | B_PCS);
      push(OP_BLT, 4'b0000, V_F); push(OP_XX, 4'b0000, V_0);   push(OP_XX, 4'b1000, V_0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL branch cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ldur();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(OP_LDUR, 4'b0000, V_F);
      push(OP_XX, 4'b0010, V_0);
      push(OP_XX, 4'b0000, V_EMEM);
      push(OP_XX, 4'b0000, V_EMEM | B_DR);
      push(OP_XX, 4'b0000, V_EMEM | B_DR);
      push(OP_XX, 4'b0010, V_EMEM | B_DR);
      push(OP_XX, 4'b0000, B_RW | B_M2R);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL ldur cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(OP_STUR, 4'b0000, V_F);
      push(OP_XX, 4'b0000, B_R2L);
      push(OP_XX, 4'b0000, V_EMEM);
      push(OP_XX, 4'b0010, V_EMEM | B_DW);
      push(OP_ADDI, 4'b0000, V_F);
      push(OP_XX, 4'b0000, V_0);
      push(OP_XX, 4'b0000, B_ASRC | A_ADD);
      push(OP_XX, 4'b0000, B_RW);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL back_to_back cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ack_on_timeout();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(OP_STUR, 4'b0000, V_F);
      push(OP_XX, 4'b0000, B_R2L);
      push(OP_XX, 4'b0000, V_EMEM);
      for (int i = 0; i < TO - 1; i++) push(OP_XX, 4'b0000, V_EMEM | B_DW);
      push(OP_XX, 4'b0010, V_EMEM | B_DW);
      push(OP_ADDS, 4'b0000, V_F);
      push(OP_XX, 4'b0000, V_0);
      push(OP_XX, 4'b0000, A_ADD);
      push(OP_XX, 4'b0000, B_RW);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL ack_on_timeout cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_async_reset();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(OP_LDUR, 4'b0000, V_F);
      push(OP_XX, 4'b0000, V_0);
      push(OP_XX, 4'b0000, V_EMEM);
      push(OP_XX, 4'b0000, V_EMEM | B_DR);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL async_reset cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
      {zero, lt, dmem_ack, mul_done} = 4'b0000;
      #2;
      total++;
      if (outs !== (V_EMEM | B_DR)) begin
         bad++;
         $display("FAIL async_reset_pre got=%b exp=%b", outs, V_EMEM | B_DR);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (outs !== V_0) begin
         bad++;
         $display("FAIL async_reset_drop got=%b exp=%b", outs, V_0);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (outs !== V_0) begin
         bad++;
         $display("FAIL async_reset_idle got=%b exp=%b", outs, V_0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mul();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(OP_MUL, 4'b0000, V_F);
`ifdef MULTICYCLE_MUL_EN
      push(OP_XX, 4'b0000, B_MS);
      for (int i = 0; i < 4; i++) push(OP_XX, 4'b0010, V_0);
      push(OP_XX, 4'b0001, V_0);
      push(OP_XX, 4'b0000, B_RW);
      push(OP_ADDI, 4'b0000, V_F);
`else
      push(OP_XX, 4'b0000, V_0);
      push(OP_XX, 4'b0001, B_FLT);
      push(OP_XX, 4'b0000, B_FLT);
`endif
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL mul cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
      test_reset("mul_reset");
   endtask

   task automatic test_illegal();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(11'b00000000000, 4'b0000, V_F);
      push(OP_XX, 4'b0000, V_0);
      push(OP_XX, 4'b0011, B_FLT);
      push(OP_ADDI, 4'b1111, B_FLT);
      push(OP_XX, 4'b0000, B_FLT);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL illegal cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
      test_reset("illegal_reset");
   endtask

   task automatic test_stur_timeout();
      stim_t s;
      logic [14:0] e;
      int cyc = 0;
      push(OP_STUR, 4'b0000, V_F);
      push(OP_XX, 4'b0000, B_R2L);
      push(OP_XX, 4'b0000, V_EMEM);
      for (int i = 0; i < TO; i++) push(OP_XX, 4'b0000, V_EMEM | B_DW);
      push(OP_XX, 4'b0010, B_FLT);
      push(OP_XX, 4'b0000, B_FLT);
      push(OP_XX, 4'b0000, B_FLT);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL stur_timeout cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
      test_reset("timeout_reset");
      push(OP_LSR, 4'b0000, V_F);
      push(OP_XX, 4'b0000, V_0);
      push(OP_XX, 4'b0000, A_SHF | B_SD);
      push(OP_XX, 4'b0000, B_RW);
      cyc = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply(s);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (outs !== e) begin
            bad++;
            $display("FAIL post_fault_run cyc%0d got=%b exp=%b", cyc, outs, e);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset_n  = 1'b1;
      instr_op = 11'd0;
      {zero, lt, dmem_ack, mul_done} = 4'b0000;
      #1;
      test_reset("init");
      test_alu();
      test_branch();
      test_ldur();
      test_back_to_back();
      test_ack_on_timeout();
      test_async_reset();
      test_mul();
      test_illegal();
      test_stur_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
